// File: rtl/down_timer.sv
// Loadable down-counting timer: counts a loaded value to zero under a tick
// enable, then expires or auto-reloads, pulsing done at terminal count.
module down_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cen_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             zero_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] reload_q;
    logic             busy_q;
    logic             done_q;

    // Priority per edge: load, then stop, then start, then counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld_i) begin
                cnt_q    <= load_val_i;
                reload_q <= load_val_i;
                state_q  <= IDLE;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!stop_i && start_i && cnt_q != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop_i) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (cen_i) begin
                            if (cnt_q == WIDTH'(1)) begin
                                done_q <= 1'b1;
                                if (auto_reload_i) begin
                                    cnt_q <= reload_q;
                                end else begin
                                    cnt_q   <= '0;
                                    state_q <= EXPIRED;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                cnt_q <= cnt_q - WIDTH'(1);
                            end
                        end
                    end
                    EXPIRED: begin
                        if (!stop_i && start_i) begin
                            if (reload_q != '0) begin
                                cnt_q   <= reload_q;
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_down_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] lv = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cen = 1'b0;
    logic         ar = 1'b0;
    logic [W-1:0] cnt_o;
    logic         busy_o;
    logic         done_o;
    logic         zero_o;

    int n_total = 0;
    int n_pass  = 0;

    down_timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_i         (ld),
        .load_val_i   (lv),
        .start_i      (start),
        .stop_i       (stop),
        .cen_i        (cen),
        .auto_reload_i(ar),
        .cnt_o        (cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: timer as "running / stopped / expired" with a count.
    int m_cnt = 0;
    int m_reload = 0;
    int m_mode = 0;   // 0 stopped, 1 running, 2 expired
    int m_done = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_reload = 0; m_mode = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (ld) begin
                m_cnt = int'(lv); m_reload = int'(lv); m_mode = 0;
            end else if (m_mode == 1) begin
                if (stop) m_mode = 0;
                else if (cen) begin
                    if (m_cnt == 1) begin
                        m_done = 1;
                        if (ar) m_cnt = m_reload;
                        else begin m_cnt = 0; m_mode = 2; end
                    end else m_cnt = m_cnt - 1;
                end
            end else if (start && !stop) begin
                if (m_mode == 0) begin
                    if (m_cnt != 0) m_mode = 1;
                end else if (m_reload != 0) begin
                    m_cnt = m_reload; m_mode = 1;
                end else m_mode = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_cnt", int'(cnt_o), m_cnt);
        check("model_busy", int'(busy_o), (m_mode == 1) ? 1 : 0);
        check("model_done", int'(done_o), m_done);
        check("model_zero", int'(zero_o), (m_cnt == 0) ? 1 : 0);
    end

    task automatic step(input logic l, input logic [W-1:0] v, input logic s,
                        input logic p, input logic c, input logic a);
        ld = l; lv = v; start = s; stop = p; cen = c; ar = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dn;
        int last;
        int ticks;
        int ok;

        #12;
        check("rst_cnt", int'(cnt_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_zero", int'(zero_o), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Async reset mid-run
        step(1, 8'h23, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("pre_rst_busy", int'(busy_o), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_cnt", int'(cnt_o), 0);
        check("arst_busy", int'(busy_o), 0);
        check("arst_done", int'(done_o), 0);
        check("arst_zero", int'(zero_o), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, 0, 1, 0, 1, 0);
        check("arst_start_ignored", int'(busy_o), 0);

        // One-shot from 5
        step(1, 8'h05, 0, 0, 0, 0);
        check("os_load", int'(cnt_o), 5);
        step(0, 0, 1, 0, 0, 0);
        check("os_busy_rise", int'(busy_o), 1);
        dn = 0;
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 1, 0);
            check("os_cnt", int'(cnt_o), 5 - i);
            if (done_o) dn++;
        end
        check("os_done_last", int'(done_o), 1);
        check("os_busy_fall", int'(busy_o), 0);
        check("os_done_count", dn, 1);
        step(0, 0, 0, 0, 1, 0);
        check("os_done_pulse", int'(done_o), 0);
        step(0, 0, 1, 0, 0, 0);
        check("os_restart_cnt", int'(cnt_o), 5);
        check("os_restart_busy", int'(busy_o), 1);

        // Auto-reload with 3
        step(1, 8'h03, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        dn = 0; last = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 0, 1, 1);
            check("ar_cnt", int'(cnt_o), (i % 3 == 0) ? 3 : 3 - (i % 3));
            if (done_o) begin
                dn++;
                if (last != 0) check("ar_period", i - last, 3);
                last = i;
            end
        end
        check("ar_done_count", dn, 4);

        // Pause and resume from 10
        step(1, 8'h0A, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 1, 0);
            if (cnt_o != 8'd6 || busy_o) ok = 0;
        end
        check("pause_hold", ok, 1);
        step(0, 0, 1, 0, 0, 0);
        check("resume_busy", int'(busy_o), 1);
        ticks = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 0, 1, 0);
            if (done_o && ticks == 0) ticks = i;
        end
        check("resume_ticks", ticks, 6);

        // Zero load and cen gating
        step(1, 8'h00, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 0);
        check("zero_start_busy", int'(busy_o), 0);
        check("zero_start_done", int'(done_o), 0);
        step(1, 8'h02, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks = 0;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, (i % 2 == 0), 0);
            if (done_o && ticks == 0) ticks = i;
        end
        check("cen_gate_latency", ticks, 4);

        // Priority cases
        step(1, 8'h02, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("pri_pre_cnt", int'(cnt_o), 1);
        step(1, 8'h07, 0, 0, 1, 0);
        check("pri_ld_cnt", int'(cnt_o), 7);
        check("pri_ld_busy", int'(busy_o), 0);
        check("pri_ld_done", int'(done_o), 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        check("pri_stop_pre", int'(cnt_o), 1);
        step(0, 0, 0, 1, 1, 0);
        check("pri_stop_cnt", int'(cnt_o), 1);
        check("pri_stop_busy", int'(busy_o), 0);
        check("pri_stop_done", int'(done_o), 0);
        step(1, 8'h04, 1, 0, 0, 0);
        check("pri_ld_start", int'(busy_o), 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] v;
            logic a;
            v = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
            a = ($urandom_range(0, 49) == 0) ? ~ar : ar;
            step($urandom_range(0, 99) < 4, v, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 65, a);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b0;
                #3 rst = 1'b1;
            end
        end

        step(0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
